audio_sigma_delta: RTL

Stereo audio output stage between the Minimig audio mixer and the board's `AUDIO_L`/`AUDIO_R` pins. It accepts 15-bit signed PCM samples (`ldata`/`rdata`) with a sample strobe and linearly interpolates between successive samples. It then drives one second-order sigma-delta modulator per channel, producing registered 1-bit bitstreams for the external RC filter. It runs entirely on `clk` (28.6875 MHz) and replaces the bitstream generation currently buried in the mixer.

---
 rtl/audio_sigma_delta.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/audio_sigma_delta.sv
// Stereo PCM interpolator feeding two 2nd-order sigma-delta modulators.
// Ports: clk, rst (async high), sample_stb, ldata/rdata in; left/right/busy out. Option: AUDIO_DITHER_EN.
module audio_sigma_delta #(
  parameter int DW        = 15,
  parameter int RAMP_BITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_stb,
  input  logic [DW-1:0] ldata,
  input  logic [DW-1:0] rdata,
  output logic          left,
  output logic          right,
  output logic          busy
);

  localparam int CW = DW + RAMP_BITS;
  localparam int W1 = DW + 2;
  localparam int W2 = DW + 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RAMP = 1'b1;

  localparam logic [RAMP_BITS-1:0] CNT_LAST = '1;

  localparam logic signed [DW:0] FB_P = (DW+1)'(2**(DW-1));
  localparam logic signed [DW:0] FB_N = -FB_P;

  logic [0:0]           state;
  logic [RAMP_BITS-1:0] cnt;

  logic signed [DW-1:0] data    [2];
  logic signed [DW-1:0] tgt     [2];
  logic signed [DW-1:0] x       [2];
  logic signed [DW-1:0] xin     [2];
  logic signed [CW-1:0] cur     [2];
  logic signed [CW-1:0] stp     [2];
  logic signed [CW-1:0] stp_nxt [2];
  logic signed [CW:0]   diff    [2];
  logic signed [DW:0]   fb      [2];
  logic signed [W1+1:0] s1      [2];
  logic signed [W2+1:0] s2      [2];
  logic signed [W1-1:0] i1      [2];
  logic signed [W1-1:0] i1_n    [2];
  logic signed [W2-1:0] i2      [2];
  logic signed [W2-1:0] i2_n    [2];
  logic                 bs      [2];

  function automatic logic signed [W1-1:0] sat1(
    input logic signed [W1+1:0] v
  );
    logic [2:0] t;
    t = v[W1+1:W1-1];
    if (t == 3'b000 || t == 3'b111)
      sat1 = v[W1-1:0];
    else if (v[W1+1])
      sat1 = {1'b1, {(W1-1){1'b0}}};
    else
      sat1 = {1'b0, {(W1-1){1'b1}}};
  endfunction

  function automatic logic signed [W2-1:0] sat2(
    input logic signed [W2+1:0] v
  );
    logic [2:0] t;
    t = v[W2+1:W2-1];
    if (t == 3'b000 || t == 3'b111)
      sat2 = v[W2-1:0];
    else if (v[W2+1])
      sat2 = {1'b1, {(W2-1){1'b0}}};
    else
      sat2 = {1'b0, {(W2-1){1'b1}}};
  endfunction

`ifdef AUDIO_DITHER_EN
  logic [15:0]        lfsr;
  logic signed [DW:0] xs [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr <= 16'hACE1;
    else
      lfsr <= {1'b0, lfsr[15:1]}
            ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end
`endif

  always_comb begin
    data[0] = ldata;
    data[1] = rdata;
    for (int c = 0; c < 2; c++) begin
      // target minus current, one guard bit so the difference never wraps
      diff[c] = {data[c][DW-1], data[c], {RAMP_BITS{1'b0}}}
              - {cur[c][CW-1], cur[c]};
      stp_nxt[c] = CW'(diff[c] >>> RAMP_BITS);
      x[c] = DW'(cur[c] >>> RAMP_BITS);
`ifdef AUDIO_DITHER_EN
      xs[c] = (DW+1)'(x[c]) + (DW+1)'($signed(lfsr[1:0]));
      if (xs[c][DW] != xs[c][DW-1])
        xin[c] = xs[c][DW] ? {1'b1, {(DW-1){1'b0}}}
                           : {1'b0, {(DW-1){1'b1}}};
      else
        xin[c] = xs[c][DW-1:0];
`else
      xin[c] = x[c];
`endif
      fb[c]   = bs[c] ? FB_P : FB_N;
      s1[c]   = (W1+2)'(i1[c]) + (W1+2)'(xin[c])
              - (W1+2)'(fb[c]);
      i1_n[c] = sat1(s1[c]);
      s2[c]   = (W2+2)'(i2[c]) + (W2+2)'(i1_n[c])
              - (W2+2)'(fb[c]);
      i2_n[c] = sat2(s2[c]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      for (int c = 0; c < 2; c++) begin
        tgt[c] <= '0;
        cur[c] <= '0;
        stp[c] <= '0;
        i1[c]  <= '0;
        i2[c]  <= '0;
        bs[c]  <= 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        i1[c] <= i1_n[c];
        i2[c] <= i2_n[c];
        bs[c] <= ~i2_n[c][W2-1];
      end
      if (sample_stb) begin
        // a strobe (re)starts the ramp from wherever cur is now
        state <= RAMP;
        cnt   <= '0;
        for (int c = 0; c < 2; c++) begin
          tgt[c] <= data[c];
          stp[c] <= stp_nxt[c];
        end
      end else if (state == RAMP) begin
        cnt <= cnt + 1'b1;
        for (int c = 0; c < 2; c++) begin
          // last step snaps to target to drop truncation error
          if (cnt == CNT_LAST)
            cur[c] <= {tgt[c], {RAMP_BITS{1'b0}}};
          else
            cur[c] <= cur[c] + stp[c];
        end
        if (cnt == CNT_LAST)
          state <= IDLE;
      end
    end
  end

  assign left  = bs[0];
  assign right = bs[1];
  assign busy  = (state == RAMP);

endmodule
